// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with programmable thresholds, sticky
// error flags and a selectable standard or first-word-fall-through read port.
module fifo_param #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 8,
    parameter int FWFT  = 0,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             RESET_L,
    input  logic [WIDTH-1:0] data_in,
    input  logic             fifo_wr,
    input  logic             fifo_rd,
    input  logic [AW:0]      al_empty_in,
    input  logic [AW:0]      al_full_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             fifo_empty,
    output logic             fifo_full,
    output logic             al_empty,
    output logic             al_full,
    output logic             err_full,
    output logic             err_empty,
    output logic [AW:0]      fifo_count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             rd_ok;
    logic             wr_ok;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(DEPTH));
    assign al_empty   = (count <= al_empty_in);
    assign al_full    = (count >= al_full_in);
    assign fifo_count = count;

    // A read frees a slot, so a full FIFO still takes a same-cycle write.
    assign rd_ok = fifo_rd && !fifo_empty;
    assign wr_ok = fifo_wr && (!fifo_full || rd_ok);

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Setting an error takes priority over clearing it.
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            err_full  <= 1'b0;
            err_empty <= 1'b0;
        end else begin
            if (fifo_wr && fifo_full && !rd_ok)
                err_full <= 1'b1;
            else if (err_clr)
                err_full <= 1'b0;
            if (fifo_rd && fifo_empty)
                err_empty <= 1'b1;
            else if (err_clr)
                err_empty <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out   = fifo_empty ? '0 : mem[rd_ptr];
            assign data_valid = !fifo_empty;
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;
            logic             valid_q;

            always_ff @(posedge clk or negedge RESET_L) begin
                if (!RESET_L) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_ok;
                    if (rd_ok)
                        dout_q <= mem[rd_ptr];
                end
            end

            assign data_out   = dout_q;
            assign data_valid = valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param: standard-mode instance checked through an
// expected-data queue, plus a small FWFT instance checked directly.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       RESET_L = 1'b0;
    logic [5:0] data_in = '0;
    logic       fifo_wr = 1'b0;
    logic       fifo_rd = 1'b0;
    logic [3:0] al_empty_in = 4'd2;
    logic [3:0] al_full_in = 4'd6;
    logic       err_clr = 1'b0;
    logic [5:0] data_out;
    logic       data_valid;
    logic       fifo_empty;
    logic       fifo_full;
    logic       al_empty;
    logic       al_full;
    logic       err_full;
    logic       err_empty;
    logic [3:0] fifo_count;

    logic [7:0] din1 = '0;
    logic       wr1 = 1'b0;
    logic       rd1 = 1'b0;
    logic [7:0] dout1;
    logic       valid1;
    logic       empty1;
    logic       full1;
    logic       ae1;
    logic       af1;
    logic       ef1;
    logic       ee1;
    logic [4:0] cnt1;

    int passed = 0;
    int total  = 0;
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    fifo_param u_dut (
        .clk(clk), .RESET_L(RESET_L),
        .data_in(data_in), .fifo_wr(fifo_wr),
        .fifo_rd(fifo_rd),
        .al_empty_in(al_empty_in),
        .al_full_in(al_full_in),
        .err_clr(err_clr),
        .data_out(data_out),
        .data_valid(data_valid),
        .fifo_empty(fifo_empty),
        .fifo_full(fifo_full),
        .al_empty(al_empty), .al_full(al_full),
        .err_full(err_full),
        .err_empty(err_empty),
        .fifo_count(fifo_count)
    );

    fifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
        .clk(clk), .RESET_L(RESET_L),
        .data_in(din1), .fifo_wr(wr1),
        .fifo_rd(rd1),
        .al_empty_in(5'd2), .al_full_in(5'd14),
        .err_clr(1'b0),
        .data_out(dout1), .data_valid(valid1),
        .fifo_empty(empty1), .fifo_full(full1),
        .al_empty(ae1), .al_full(af1),
        .err_full(ef1), .err_empty(ee1),
        .fifo_count(cnt1)
    );

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
    endtask

    // Monitor: every valid word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (RESET_L && data_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_valid: got %0h expected none",
                         data_out);
            end else begin
                chk("data_out", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] d);
        fifo_wr = 1'b1;
        data_in = d;
        tick();
        fifo_wr = 1'b0;
    endtask

    task automatic rd(input logic [5:0] e);
        exp_q.push_back(e);
        fifo_rd = 1'b1;
        tick();
        fifo_rd = 1'b0;
    endtask

    task automatic clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        // 1: reset state and single word latency
        repeat (3) @(posedge clk);
        #1 RESET_L = 1'b1;
        tick();
        chk("rst_dout", 32'(data_out), 32'h0);
        chk("rst_empty", 32'(fifo_empty), 32'h1);
        chk("rst_al_empty", 32'(al_empty), 32'h1);
        chk("rst_full", 32'(fifo_full), 32'h0);
        chk("rst_al_full", 32'(al_full), 32'h0);
        chk("rst_count", 32'(fifo_count), 32'h0);
        chk("rst_errs", 32'({err_full, err_empty}), 32'h0);
        wr(6'b010010);
        chk("t1_cnt1", 32'(fifo_count), 32'h1);
        rd(6'b010010);
        chk("t1_valid", 32'(data_valid), 32'h1);
        chk("t1_cnt0", 32'(fifo_count), 32'h0);
        tick();
        chk("t1_valid_drop", 32'(data_valid), 32'h0);

        // 2: fill, thresholds, overflow, drain in order
        for (int i = 0; i < 8; i++) begin
            wr(6'(i));
            chk("t2_al_empty", 32'(al_empty), 32'(i + 1 <= 2));
            chk("t2_al_full", 32'(al_full), 32'(i + 1 >= 6));
            chk("t2_full", 32'(fifo_full), 32'(i + 1 == 8));
        end
        wr(6'h3F);
        chk("t2_err_full", 32'(err_full), 32'h1);
        chk("t2_cnt8", 32'(fifo_count), 32'h8);
        for (int i = 0; i < 8; i++)
            rd(6'(i));
        chk("t2_cnt0", 32'(fifo_count), 32'h0);
        clr();
        chk("t2_err_clr", 32'(err_full), 32'h0);

        // 3: underflow and sticky clear behaviour
        tick();
        fifo_rd = 1'b1;
        tick();
        fifo_rd = 1'b0;
        chk("t3_err_empty", 32'(err_empty), 32'h1);
        chk("t3_valid", 32'(data_valid), 32'h0);
        chk("t3_dout_hold", 32'(data_out), 32'h07);
        chk("t3_cnt", 32'(fifo_count), 32'h0);
        clr();
        chk("t3_clr", 32'(err_empty), 32'h0);
        err_clr = 1'b1;
        fifo_rd = 1'b1;
        tick();
        err_clr = 1'b0;
        fifo_rd = 1'b0;
        chk("t3_set_wins", 32'(err_empty), 32'h1);
        clr();

        // 4a: full with simultaneous read and write
        for (int i = 0; i < 8; i++)
            wr(6'(8'h10 + i));
        exp_q.push_back(6'h10);
        fifo_rd = 1'b1;
        fifo_wr = 1'b1;
        data_in = 6'h2A;
        tick();
        fifo_rd = 1'b0;
        fifo_wr = 1'b0;
        chk("t4_cnt8", 32'(fifo_count), 32'h8);
        chk("t4_no_err_full", 32'(err_full), 32'h0);
        for (int i = 1; i < 8; i++)
            rd(6'(8'h10 + i));
        rd(6'h2A);
        chk("t4_drained", 32'(fifo_count), 32'h0);

        // 4b: empty with simultaneous read and write
        tick();
        fifo_rd = 1'b1;
        fifo_wr = 1'b1;
        data_in = 6'h15;
        tick();
        fifo_rd = 1'b0;
        fifo_wr = 1'b0;
        chk("t4b_cnt1", 32'(fifo_count), 32'h1);
        chk("t4b_err_empty", 32'(err_empty), 32'h1);
        chk("t4b_valid", 32'(data_valid), 32'h0);
        rd(6'h15);
        clr();

        // 5: pointer wrap over several rounds
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 5; k++)
                wr(6'(8'h20 + r * 5 + k));
            chk("t5_cnt5", 32'(fifo_count), 32'h5);
            for (int k = 0; k < 5; k++)
                rd(6'(8'h20 + r * 5 + k));
            chk("t5_cnt0", 32'(fifo_count), 32'h0);
        end

        // 6: asynchronous reset between edges
        for (int k = 0; k < 5; k++)
            wr(6'(k + 1));
        chk("t6_cnt5", 32'(fifo_count), 32'h5);
        @(negedge clk);
        #2 RESET_L = 1'b0;
        #1;
        chk("t6_async_cnt", 32'(fifo_count), 32'h0);
        chk("t6_async_empty", 32'(fifo_empty), 32'h1);
        tick();
        RESET_L = 1'b1;
        tick();

        // 6b: FWFT instance presents head without a read
        chk("t6_fwft_idle", 32'(valid1), 32'h0);
        din1 = 8'hA5;
        wr1 = 1'b1;
        tick();
        wr1 = 1'b0;
        chk("t6_fwft_dout", 32'(dout1), 32'hA5);
        chk("t6_fwft_valid", 32'(valid1), 32'h1);
        rd1 = 1'b1;
        tick();
        rd1 = 1'b0;
        chk("t6_fwft_popped", 32'(valid1), 32'h0);
        chk("t6_fwft_cnt", 32'(cnt1), 32'h0);

        repeat (3) tick();
        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO that replaces the fixed 6-bit data buffer.
- Generic data width and depth.
- Programmable almost-empty and almost-full thresholds.
- Occupancy count output.
- Sticky overflow and underflow error flags with clear.
- Selectable standard or first-word-fall-through (FWFT) read mode.
- Buffers words between producer and consumer stages in one clock domain.

Parameters:
- WIDTH, 6: data word width in bits.
- DEPTH, 8: number of entries; power of 2, ≥4.
- FWFT, 0: 0 = standard registered read, 1 = first-word-fall-through.
- AW, $clog2(DEPTH): localparam pointer width; count/threshold width is AW+1.

Ports:
- clk  in  1  clock, rising edge.
- RESET_L  in  1  asynchronous active-low reset.
- data_in  in  WIDTH  write data.
- fifo_wr  in  1  write request.
- fifo_rd  in  1  read request / pop.
- al_empty_in  in  AW+1  almost-empty threshold.
- al_full_in  in  AW+1  almost-full threshold.
- err_clr  in  1  clears sticky error flags.
- data_out  out  WIDTH  read data.
- data_valid  out  1  data_out holds a valid popped/head word.
- fifo_empty  out  1  count == 0.
- fifo_full  out  1  count == DEPTH.
- al_empty  out  1  count <= al_empty_in.
- al_full  out  1  count >= al_full_in.
- err_full  out  1  sticky overflow.
- err_empty  out  1  sticky underflow.
- fifo_count  out  AW+1  current occupancy.

Behaviour:
- Reset (RESET_L low, async, takes effect immediately, mid-operation included):
  - rd/wr pointers = 0, count = 0, data_out = 0, data_valid = 0.
  - fifo_empty = 1, al_empty = 1, fifo_full = 0, al_full = 0, err_full = 0, err_empty = 0.
  - Memory contents are don't-care.
- rd_ok = fifo_rd && !fifo_empty.
  - A read on an empty FIFO is rejected even if a write occurs in the same cycle.
- wr_ok = fifo_wr && (!fifo_full || rd_ok).
  - A write on a full FIFO is accepted when a read is accepted in the same cycle.
- Accepted write: mem[wr_ptr] <= data_in, wr_ptr increments modulo DEPTH (natural wrap).
- Accepted read: rd_ptr increments modulo DEPTH.
- Count update:
  - +1 on wr_ok only.
  - −1 on rd_ok only.
  - Unchanged on both or neither.
- Status flags are combinational decodes of the registered count; they change in the cycle after the accepting edge.
- Threshold edge cases:
  - al_full_in > DEPTH: al_full never asserts.
  - al_empty_in = 0: al_empty equals fifo_empty.
  - Thresholds may change at any time; flags follow immediately.
- Standard mode (FWFT=0):
  - On rd_ok, data_out <= head word at the clock edge; data_valid = 1 for exactly that following cycle.
  - Latency is 1 cycle from the rd edge.
  - data_out holds its last value when no read is accepted; data_valid = 0.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] whenever !fifo_empty; data_valid = !fifo_empty.
  - fifo_rd acknowledges and pops the presented word.
  - The first word appears the cycle after the write edge.
- Overflow: fifo_wr && fifo_full && !rd_ok sets err_full.
  - Word dropped; memory, pointers and count unchanged.
- Underflow: fifo_rd && fifo_empty sets err_empty.
  - Pointers and count unchanged, data_out unchanged, data_valid = 0.
- Error flags are sticky until err_clr is sampled high.
  - If err_clr and a new error occur in the same cycle, set wins and the flag stays 1.
- Full→empty→full wrap cycles preserve strict FIFO ordering across pointer wrap.

Test Plan:
Default parameters unless stated; al_empty_in = 2, al_full_in = 6.
1. Reset, then hold idle -> data_out = 0, fifo_empty = 1, al_empty = 1, fifo_count = 0, error flags 0. Then write 6'b010010, read next cycle -> data_out = 6'b010010 with data_valid high one cycle after the rd edge; count 0→1→0.
2. Write 8 words 0x00..0x07 -> al_empty drops when count = 3, al_full rises at count = 6, fifo_full at 8. 9th write 0x3F -> err_full = 1, count stays 8. Read 8 -> outputs 0x00..0x07 in order, 0x3F never appears.
3. Read while empty -> err_empty = 1, data_out unchanged, data_valid = 0. Pulse err_clr -> err_empty = 0. err_clr together with a new empty read -> err_empty stays 1.
4. Simultaneous events:
   - Full, rd+wr of 0x2A -> count stays 8, no err_full, 0x2A is read out last.
   - Empty, rd+wr of 0x15 -> write accepted, count = 1, err_empty = 1.
5. Wrap: write 5 / read 5 repeatedly for 4 rounds (pointers wrap several times) -> every word returned in order, count returns to 0.
6. Reset mid-run: with count = 5, drop RESET_L between clock edges -> fifo_count = 0 and fifo_empty = 1 immediately. In an FWFT=1, WIDTH=8, DEPTH=16 instance, write 0xA5 -> data_out = 0xA5, data_valid = 1 the next cycle without fifo_rd; fifo_rd pops it -> data_valid = 0.
